// File: rtl/wordlit_rr_sched.sv
// ---------------------------------------------------------------------------
// wordlit_rr_sched
//
// Round-robin scheduler that shares one word-literal transform between NREQ
// requesters. The transform is out = {8'h00, data} ^ lit. The result is
// held in a one-entry output register until it is accepted downstream.
//
// Optional feature macro: WORDLIT_SCHED_STATS_EN
//   defined   : per-requester saturating 16-bit grant counters on stat_cnt
//   undefined : stat_cnt tied to 0, no counter flops
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-low reset (0 = reset)
//   req_valid  per-requester valid
//   req_data   per-requester byte, requester i owns [8i+7:8i]
//   req_ready  one-hot accept (combinational)
//   cfg_we     literal write strobe
//   cfg_lit    new literal value
//   lit_q      current literal
//   out_valid  result valid
//   out_ready  downstream accept
//   out_data   transformed word
//   out_id     requester index that produced out_data
//   stat_cnt   per-requester grant counts, slice i at [16i+15:16i]
//
// Handshake rule (both sides): a word moves in a cycle where valid and
// ready are both 1 at the rising clock edge. A source holding valid=1 must
// keep valid and data stable until it sees ready=1; out_valid is only
// withdrawn after an accepted word, or by reset.
// ---------------------------------------------------------------------------
module wordlit_rr_sched #(
  parameter int unsigned  NREQ = 4,
  parameter int unsigned  IDW  = 2,
  parameter logic [15:0]  LIT  = 16'h0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*8-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 cfg_we,
  input  logic [15:0]          cfg_lit,
  output logic [15:0]          lit_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data,
  output logic [IDW-1:0]       out_id,
  output logic [NREQ*16-1:0]   stat_cnt
);

  // EMPTY: output register holds nothing; FULL: out_data/out_id are valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IDW-1:0]  ptr_q;

  logic            can_issue;
  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic            grant;
  logic [7:0]      gnt_data;

  assign out_valid = (state_q == FULL);
  assign can_issue = !out_valid || out_ready;

  // Search ptr, ptr+1, ... wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  assign grant = gnt_found && can_issue;

  // One-hot ready plus the byte of the granted requester.
  always_comb begin
    req_ready = '0;
    gnt_data  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_idx == IDW'(i)) begin
        req_ready[i] = grant;
        gnt_data     = req_data[8*i +: 8];
      end
    end
  end

  // State machine: register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // State machine: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (grant) state_d = FULL;
      end
      FULL: begin
        // A grant while FULL implies out_ready=1, so the slot is refilled.
        if (out_ready && !grant) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Datapath, pointer and literal. The grant reads lit_q before any cfg_we
  // update lands, so a same-cycle write only affects later grants.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
      out_id   <= '0;
      ptr_q    <= '0;
      lit_q    <= LIT;
    end else begin
      if (grant) begin
        out_data <= {8'h00, gnt_data} ^ lit_q;
        out_id   <= gnt_idx;
        ptr_q    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (cfg_we) begin
        lit_q <= cfg_lit;
      end
    end
  end

`ifdef WORDLIT_SCHED_STATS_EN
  logic [15:0] cnt_q [NREQ];

  // Saturating grant counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREQ); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (grant && gnt_idx == IDW'(i) && cnt_q[i] != 16'hFFFF) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < int'(NREQ); i++) stat_cnt[16*i +: 16] = cnt_q[i];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_wordlit_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_wordlit_rr_sched
//
// Directed bench for wordlit_rr_sched with NREQ=4 and the default literal.
// Inputs change 1 time unit after the rising edge; registered outputs are
// sampled there, req_ready one further time unit later once inputs settle.
// ---------------------------------------------------------------------------
module tb_wordlit_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              cfg_we;
  logic [15:0]       cfg_lit;
  logic [15:0]       lit_q;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [IDW-1:0]    out_id;
  logic [NREQ*16-1:0] stat_cnt;

  int tests_run;
  int tests_failed;

  wordlit_rr_sched #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .LIT  (16'h0001)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cfg_we    (cfg_we),
    .cfg_lit   (cfg_lit),
    .lit_q     (lit_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .stat_cnt  (stat_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    cfg_we    = 1'b0;
    cfg_lit   = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (out_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_out_data: got %h expected 0000", out_data);
    end
    tests_run++;
    if (out_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_out_id: got %0d expected 0", out_id);
    end
    tests_run++;
    if (lit_q !== 16'h0001) begin
      tests_failed++;
      $display("FAIL reset_lit_q: got %h expected 0001", lit_q);
    end
    tests_run++;
    if (stat_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_stat_cnt: got %h expected 0", stat_cnt);
    end
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
    end
  endtask

  // req1 sends A5; 00A5 ^ 0001 = 00A4 one cycle later.
  task automatic test_single();
    req_valid = 4'b0010;
    req_data  = '0;
    req_data[15:8] = 8'hA5;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL single_req_ready: got %b expected 0010", req_ready);
    end
    step();
    req_valid = 4'b0000;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 16'h00A4 || out_id !== 2'd1) begin
      tests_failed++;
      $display("FAIL single_result: got v=%b d=%h id=%0d expected v=1 d=00a4 id=1",
               out_valid, out_data, out_id);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  // All four valid, ptr reset to 0: grants 0,1,2,3,0, one per cycle.
  task automatic test_fairness();
    int exp_order [5];
    logic [15:0] exp_data;
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b0;
    #1;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'h10 + 8'(i);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      tests_run++;
      if (req_ready !== 4'(1 << exp_order[n])) begin
        tests_failed++;
        $display("FAIL fair_req_ready[%0d]: got %b expected %b",
                 n, req_ready, 4'(1 << exp_order[n]));
      end
      step();
      exp_data = {8'h00, 8'h10 + 8'(exp_order[n])} ^ 16'h0001;
      tests_run++;
      if (out_valid !== 1'b1 || out_id !== 2'(exp_order[n]) || out_data !== exp_data) begin
        tests_failed++;
        $display("FAIL fair_word[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                 n, out_valid, out_id, out_data, exp_order[n], exp_data);
      end
    end
  endtask

  // Held word (id0, 0011) stays put for 3 stalled cycles; then req1 is next.
  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      tests_run++;
      if (req_ready !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bp_req_ready[%0d]: got %b expected 0000", n, req_ready);
      end
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 16'h0011) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h expected v=1 id=0 d=0011",
                 n, out_valid, out_id, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bp_release_ready: got %b expected 0010", req_ready);
    end
    step();
    req_valid = 4'b0000;
    tests_run++;
    if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 16'h0010) begin
      tests_failed++;
      $display("FAIL bp_release_word: got v=%b id=%0d d=%h expected v=1 id=1 d=0010",
               out_valid, out_id, out_data);
    end
    step();
  endtask

  // Same-cycle literal write: first word uses 0001, second uses FF00.
  task automatic test_config_race();
    req_data  = '0;
    req_data[7:0] = 8'h0F;
    req_valid = 4'b0001;
    cfg_we    = 1'b1;
    cfg_lit   = 16'hFF00;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL cfg_req_ready: got %b expected 0001", req_ready);
    end
    step();
    cfg_we = 1'b0;
    tests_run++;
    if (out_data !== 16'h000E || out_id !== 2'd0 || lit_q !== 16'hFF00) begin
      tests_failed++;
      $display("FAIL cfg_first_word: got d=%h id=%0d lit=%h expected d=000e id=0 lit=ff00",
               out_data, out_id, lit_q);
    end
    step();
    req_valid = 4'b0000;
    out_ready = 1'b0;
    tests_run++;
    if (out_data !== 16'hFF0F) begin
      tests_failed++;
      $display("FAIL cfg_second_word: got %h expected ff0f", out_data);
    end
    // Literal change while held must not alter the held word.
    cfg_we  = 1'b1;
    cfg_lit = 16'h1234;
    step();
    cfg_we = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 16'hFF0F || lit_q !== 16'h1234) begin
      tests_failed++;
      $display("FAIL cfg_held_word: got v=%b d=%h lit=%h expected v=1 d=ff0f lit=1234",
               out_valid, out_data, lit_q);
    end
  endtask

  // Async reset with a held word: output dropped at once, ptr back to 0.
  task automatic test_reset_mid();
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || lit_q !== 16'h0001 || out_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rstmid_state: got v=%b lit=%h d=%h expected v=0 lit=0001 d=0000",
               out_valid, lit_q, out_data);
    end
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'h20 + 8'(i);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rstmid_req_ready: got %b expected 0001", req_ready);
    end
    step();
    req_valid = 4'b0000;
    tests_run++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 16'h0021) begin
      tests_failed++;
      $display("FAIL rstmid_word: got v=%b id=%0d d=%h expected v=1 id=0 d=0021",
               out_valid, out_id, out_data);
    end
    step();
  endtask

`ifdef WORDLIT_SCHED_STATS_EN
  // 3 grants to req0, then 70000 to req2 (saturates at FFFF).
  task automatic test_stats();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    req_valid = 4'b0001;
    repeat (3) step();
    req_valid = 4'b0100;
    repeat (70000) step();
    req_valid = 4'b0000;
    step();
    tests_run++;
    if (stat_cnt[15:0] !== 16'd3) begin
      tests_failed++;
      $display("FAIL stats_slice0: got %h expected 0003", stat_cnt[15:0]);
    end
    tests_run++;
    if (stat_cnt[31:16] !== 16'd0 || stat_cnt[63:48] !== 16'd0) begin
      tests_failed++;
      $display("FAIL stats_slice1_3: got %h/%h expected 0000/0000",
               stat_cnt[31:16], stat_cnt[63:48]);
    end
    tests_run++;
    if (stat_cnt[47:32] !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL stats_slice2: got %h expected ffff", stat_cnt[47:32]);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_config_race();
    test_reset_mid();
`ifdef WORDLIT_SCHED_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
